// File: rtl/spi_sample_packer.sv
// Packs pairs of SPI bytes (high byte first) into 16-bit samples and queues them
// in a first-word-fall-through FIFO for the downstream FIR stage.
module spi_sample_packer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  input  logic                       msg_start,
  output logic [15:0]                sample_data,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {WANT_HI = 1'b0, WANT_LO = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_hi_byte;
  logic [7:0]     w_hi_byte_nxt;
  logic           w_push;

  logic [15:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic           r_overflow;

  logic           w_full;
  logic           w_pop;
  logic           w_do_push;
  logic           w_drop;

  // Byte-phase next state; a frame start always restarts at the high byte.
  always_comb begin
    w_state_nxt   = r_state;
    w_hi_byte_nxt = r_hi_byte;
    w_push        = 1'b0;
    if (msg_start) begin
      if (byte_valid) begin
        w_state_nxt   = WANT_LO;
        w_hi_byte_nxt = byte_data;
      end else begin
        w_state_nxt   = WANT_HI;
        w_hi_byte_nxt = 8'h00;
      end
    end else if (byte_valid) begin
      case (r_state)
        WANT_HI: begin
          w_state_nxt   = WANT_LO;
          w_hi_byte_nxt = byte_data;
        end
        WANT_LO: begin
          w_state_nxt = WANT_HI;
          w_push      = 1'b1;
        end
        default: begin
          w_state_nxt   = WANT_HI;
          w_hi_byte_nxt = 8'h00;
        end
      endcase
    end else begin
      w_state_nxt   = r_state;
      w_hi_byte_nxt = r_hi_byte;
    end
  end

  // Byte-phase state and held high byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WANT_HI;
      r_hi_byte <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_hi_byte <= w_hi_byte_nxt;
    end
  end

  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  always_comb begin
    w_full    = (r_level == LW'(DEPTH));
    w_pop     = (r_level != {LW{1'b0}}) && sample_ready;
    w_do_push = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= {r_hi_byte, byte_data};
        r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      if (w_do_push && !w_pop) begin
        r_level <= r_level + LW'(1'b1);
      end else if (w_pop && !w_do_push) begin
        r_level <= r_level - LW'(1'b1);
      end
    end
  end

  // Sticky drop flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign sample_data  = r_mem[r_rd_ptr];
  assign sample_valid = (r_level != {LW{1'b0}});
  assign level        = r_level;
  assign overflow     = r_overflow;

endmodule

// File: doc/spi_sample_packer.md
SPI_SAMPLE_PACKER -- requirements
Module: spi_sample_packer

Interface
REQ-001 Parameter: DEPTH, default 4, sample FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port byte_valid, input, 1 bit: one-cycle strobe; byte_data holds a received SPI byte.
REQ-005 The block SHALL have port byte_data, input, 8 bits: received byte, MSB-first bus order.
REQ-006 The block SHALL have port msg_start, input, 1 bit: one-cycle pulse at each SSEL falling edge (frame start).
REQ-007 The block SHALL have port sample_data, output, 16 bits: FIFO head sample, valid only when sample_valid is high.
REQ-008 The block SHALL have port sample_valid, output, 1 bit: FIFO not empty.
REQ-009 The block SHALL have port sample_ready, input, 1 bit: FIR stage accepts the head sample.
REQ-010 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag; set when a sample is dropped.
REQ-012 The block SHALL have port clear_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-013 The byte-phase FSM SHALL have two states: WANT_HI and WANT_LO.
REQ-014 In WANT_HI with byte_valid, the FSM SHALL latch byte_data as the high byte and go to WANT_LO.
REQ-015 In WANT_LO with byte_valid, the FSM SHALL push {high byte, byte_data} to the FIFO and go to WANT_HI.
REQ-016 msg_start SHALL force WANT_HI and discard any held high byte.
REQ-017 When msg_start and byte_valid coincide, the byte SHALL be taken as the high byte of a new sample, and the state SHALL become WANT_LO.
REQ-018 The FIFO SHALL be first-word-fall-through: sample_valid = (level != 0), and sample_data = entry at the read pointer.
REQ-019 Push-to-visible latency SHALL be 1 cycle: sample_valid rises the cycle after the low-byte strobe when the FIFO was empty.
REQ-020 A pop SHALL occur only when sample_valid && sample_ready; sample_data and sample_valid SHALL stay stable while sample_valid && !sample_ready.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-022 A push while full without a concurrent pop SHALL drop the sample, leave the FIFO unchanged, and set overflow.
REQ-023 A push and a pop in the same cycle SHALL both complete at any occupancy, including full, with level unchanged.
REQ-024 A pop at level 1 with a concurrent push SHALL yield level 1, with the new sample at the head the next cycle.
REQ-025 overflow set SHALL take priority over clear_ovf in the same cycle.
REQ-026 msg_start SHALL NOT flush the FIFO; completed samples survive frame boundaries.

Reset
REQ-027 rst_n low SHALL immediately force: state WANT_HI, held byte 0, pointers 0, level 0, sample_valid 0, sample_data 16'h0000, overflow 0, and all FIFO entries 0.
REQ-028 Reset asserted mid-sample (in WANT_LO) SHALL discard the held high byte, and the first byte after release SHALL be a high byte.
REQ-029 Outputs SHALL be registered, or derived only from registered state, with no combinational path from byte_valid to sample_valid.

Verification
REQ-030 Bytes 0x12 then 0x34, sample_ready=1 -> sample_data=16'h1234, sample_valid high for exactly 1 cycle, 1 cycle after the 0x34 strobe.
REQ-031 Byte 0xAB, then msg_start, then 0xCD and 0xEF -> only 16'hCDEF emitted; 0xAB discarded.
REQ-032 sample_ready=0, push DEPTH+1 samples 16'h0001..16'h0005 -> level=4, overflow=1; draining yields 16'h0001..16'h0004.
REQ-033 FIFO full, push and pop in the same cycle -> level stays 4, overflow stays 0, output order preserved.
REQ-034 rst_n pulsed low after a high byte 0x55, then bytes 0x66, 0x77 -> 16'h6677 emitted, and all outputs read 0 during reset.
REQ-035 overflow=1, clear_ovf asserted with no concurrent drop -> overflow=0 next cycle; clear_ovf concurrent with a drop -> overflow stays 1.
